// File: rtl/multi_ball_renderer.sv
// multi_ball_renderer: draws N_BALLS bouncing balls with shadow rings over a
// solid background. Colour and syncs leave two clocks after the sync
// generator's position, and ball motion is advanced once per frame in
// vertical blank, one ball per clock.
module multi_ball_renderer #(
    parameter int          N_BALLS  = 4,
    parameter int          RADIUS   = 20,
    parameter int          SHADOW   = 4,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [5:0]  BG_COLOR = 6'b00_00_10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pause,
    input  logic [2:0]  speed,
    output logic [5:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        busy
);

    localparam int          IDX_W    = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BALLS - 1);
    localparam logic [10:0] X_HI     = 11'(H_ACTIVE - RADIUS);
    localparam logic [10:0] Y_HI     = 11'(V_ACTIVE - RADIUS);
    localparam logic [10:0] POS_LO   = 11'(RADIUS);
    localparam logic [9:0]  NEAR_LIM = 10'(RADIUS + SHADOW);
    localparam logic [20:0] HIT_SQ   = 21'(RADIUS * RADIUS);
    localparam logic [20:0] SHADE_SQ = 21'((RADIUS + SHADOW) * (RADIUS + SHADOW));
    localparam logic [5:0]  SHADE_COLOR = 6'b01_01_01;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    // One axis step with clamped bounce; result is {newDir, newPos}.
    function automatic logic [10:0] stepAxis(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [3:0]  step,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] wide;
        logic [10:0] sum;
        wide = {1'b0, pos};
        sum  = wide + {7'd0, step};
        if (dir) begin
            if (sum >= hi) return {1'b0, hi[9:0]};
            else           return {1'b1, sum[9:0]};
        end else begin
            if (wide <= lo + {7'd0, step}) return {1'b1, lo[9:0]};
            else                           return {1'b0, pos - {6'd0, step}};
        end
    endfunction

    // Ball colour chosen by index modulo four.
    function automatic logic [5:0] palette(input int i);
        case (i % 4)
            0:       return 6'b11_10_00;
            1:       return 6'b11_00_00;
            2:       return 6'b00_11_00;
            default: return 6'b11_00_11;
        endcase
    endfunction

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       step_q;
    logic             busy_q;
    logic [9:0]       x_q    [N_BALLS];
    logic [9:0]       y_q    [N_BALLS];
    logic             xdir_q [N_BALLS];
    logic             ydir_q [N_BALLS];
    logic [10:0]      xUpd_d;
    logic [10:0]      yUpd_d;

    logic [9:0]       adx_d  [N_BALLS];
    logic [9:0]       ady_d  [N_BALLS];
    logic             near_d [N_BALLS];
    logic [9:0]       adx_q  [N_BALLS];
    logic [9:0]       ady_q  [N_BALLS];
    logic             near_q [N_BALLS];
    logic             disp1_q;
    logic             hs1_q;
    logic             vs1_q;

    logic [20:0]      dist_d [N_BALLS];
    logic [N_BALLS-1:0] hit_d;
    logic [N_BALLS-1:0] shade_d;
    logic [5:0]       rgb_d;
    logic [5:0]       rgb_q;
    logic             hs2_q;
    logic             vs2_q;

    // Next position and direction of the ball currently being updated.
    always_comb begin
        xUpd_d = stepAxis(x_q[idx_q], xdir_q[idx_q], step_q, POS_LO, X_HI);
        yUpd_d = stepAxis(y_q[idx_q], ydir_q[idx_q], step_q, POS_LO, Y_HI);
    end

    // Update FSM: on the vblank trigger, walk every ball once with a latched step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            step_q  <= 4'd1;
            busy_q  <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) begin
                x_q[i]    <= 10'(H_ACTIVE / 2 + 32 * i);
                y_q[i]    <= 10'(V_ACTIVE / 2 - 16 * i);
                xdir_q[i] <= ((i % 2) == 0);
                ydir_q[i] <= (((i / 2) % 2) == 0);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (hpos == 10'd0 && vpos == 10'(V_ACTIVE) && !pause) begin
                        state_q <= UPDATE;
                        idx_q   <= '0;
                        step_q  <= {1'b0, speed} + 4'd1;
                        busy_q  <= 1'b1;
                    end
                end
                UPDATE: begin
                    x_q[idx_q]    <= xUpd_d[9:0];
                    xdir_q[idx_q] <= xUpd_d[10];
                    y_q[idx_q]    <= yUpd_d[9:0];
                    ydir_q[idx_q] <= yUpd_d[10];
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-ball axis distances from the current pixel and a coarse proximity box.
    always_comb begin
        for (int i = 0; i < N_BALLS; i++) begin
            adx_d[i]  = (hpos >= x_q[i]) ? (hpos - x_q[i]) : (x_q[i] - hpos);
            ady_d[i]  = (vpos >= y_q[i]) ? (vpos - y_q[i]) : (y_q[i] - vpos);
            near_d[i] = (adx_d[i] <= NEAR_LIM) && (ady_d[i] <= NEAR_LIM);
        end
    end

    // Pixel stage 1: capture distances, proximity flags and the video controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BALLS; i++) begin
                adx_q[i]  <= '0;
                ady_q[i]  <= '0;
                near_q[i] <= 1'b0;
            end
            disp1_q <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BALLS; i++) begin
                adx_q[i]  <= adx_d[i];
                ady_q[i]  <= ady_d[i];
                near_q[i] <= near_d[i];
            end
            disp1_q <= display_on;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
        end
    end

    // Squared distance tests and colour priority: lowest-index hit, then shade, then background.
    always_comb begin
        hit_d   = '0;
        shade_d = '0;
        rgb_d   = BG_COLOR;
        for (int i = 0; i < N_BALLS; i++) begin
            dist_d[i]  = {11'd0, adx_q[i]} * {11'd0, adx_q[i]}
                       + {11'd0, ady_q[i]} * {11'd0, ady_q[i]};
            hit_d[i]   = near_q[i] && (dist_d[i] <= HIT_SQ);
            shade_d[i] = near_q[i] && (dist_d[i] <= SHADE_SQ);
        end
        if (|shade_d) rgb_d = SHADE_COLOR;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            if (hit_d[i]) rgb_d = palette(i);
        end
        if (!disp1_q) rgb_d = 6'b00_00_00;
    end

    // Pixel stage 2: registered colour and the second sync delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multi_ball_renderer.sv
// tb_multi_ball_renderer: directed checks of colour, sync delay, ball motion,
// pause, bounce clamping and reset abort for multi_ball_renderer.
module tb_multi_ball_renderer;

    logic       clk;
    logic       rst_n;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       pause;
    logic [2:0] speed;
    logic [5:0] rgb;
    logic       hsync_out;
    logic       vsync_out;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int busyCnt;

    localparam logic [5:0] BG    = 6'b00_00_10;
    localparam logic [5:0] SHADE = 6'b01_01_01;
    localparam logic [5:0] COL0  = 6'b11_10_00;
    localparam logic [5:0] COL1  = 6'b11_00_00;
    localparam logic [5:0] COL2  = 6'b00_11_00;
    localparam logic [5:0] COL3  = 6'b11_00_11;

    multi_ball_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pause      (pause),
        .speed      (speed),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a pixel and check the colour two clocks later.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic disp,
                                 input logic [5:0] exp, input string tag);
        hpos       = h;
        vpos       = v;
        display_on = disp;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(tag, 32'(rgb), 32'(exp));
    endtask

    // Fire one vblank trigger and count busy cycles over a bounded window.
    task automatic doFrame(input logic [2:0] spdDuring, output int cnt);
        hpos = 10'd0;
        vpos = 10'd480;
        @(posedge clk);
        #1;
        hpos  = 10'd1;
        speed = spdDuring;
        cnt   = 0;
        repeat (10) begin
            if (busy === 1'b1) cnt++;
            @(posedge clk);
            #1;
        end
        vpos = 10'd0;
    endtask

    initial begin
        rst_n      = 1'b0;
        hpos       = 10'd0;
        vpos       = 10'd0;
        display_on = 1'b0;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        pause      = 1'b0;
        speed      = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rgb", 32'(rgb), 32'd0);
        checkOutput("reset_hsync", 32'(hsync_out), 32'd0);
        checkOutput("reset_vsync", 32'(vsync_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Colours at reset positions: balls at (320,240) (352,224) (384,208) (416,192).
        applyStimulus(10'd320, 10'd240, 1'b1, COL0, "ball0_centre");
        applyStimulus(10'd0,   10'd0,   1'b1, BG,   "background");
        applyStimulus(10'd320, 10'd240, 1'b0, 6'd0, "blanked");
        applyStimulus(10'd300, 10'd240, 1'b1, COL0, "edge_r20");
        applyStimulus(10'd298, 10'd240, 1'b1, SHADE, "shadow_r22");
        applyStimulus(10'd296, 10'd240, 1'b1, SHADE, "shadow_r24");
        applyStimulus(10'd295, 10'd240, 1'b1, BG,   "outside_r25");
        applyStimulus(10'd336, 10'd232, 1'b1, COL0, "overlap_0_1");
        applyStimulus(10'd352, 10'd224, 1'b1, COL1, "ball1_centre");
        applyStimulus(10'd384, 10'd208, 1'b1, COL2, "ball2_centre");
        applyStimulus(10'd416, 10'd192, 1'b1, COL3, "ball3_centre");

        // Sync pulses must come out exactly two clocks later.
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        @(posedge clk);
        #1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        checkOutput("hsync_d1", 32'(hsync_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hsync_d2", 32'(hsync_out), 32'd1);
        checkOutput("vsync_d2", 32'(vsync_out), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("hsync_d3", 32'(hsync_out), 32'd0);

        // First frame, step 1; a speed change during the update must be ignored.
        display_on = 1'b0;
        speed = 3'd0;
        doFrame(3'd7, busyCnt);
        speed = 3'd0;
        checkOutput("busy_cycles", 32'(busyCnt), 32'd4);
        checkOutput("ball0_x", 32'(dut.x_q[0]), 32'd321);
        checkOutput("ball0_y", 32'(dut.y_q[0]), 32'd241);
        checkOutput("ball1_x", 32'(dut.x_q[1]), 32'd351);
        checkOutput("ball1_y", 32'(dut.y_q[1]), 32'd225);
        checkOutput("ball3_x", 32'(dut.x_q[3]), 32'd415);

        // Paused triggers leave everything alone.
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            doFrame(3'd0, busyCnt);
            checkOutput("pause_busy", 32'(busyCnt), 32'd0);
        end
        pause = 1'b0;
        checkOutput("pause_x0", 32'(dut.x_q[0]), 32'd321);
        checkOutput("pause_y0", 32'(dut.y_q[0]), 32'd241);

        // 297 more step-1 frames carry ball 0 from 321 to 618.
        for (int k = 0; k < 297; k++) begin
            doFrame(3'd0, busyCnt);
        end
        checkOutput("run_x0", 32'(dut.x_q[0]), 32'd618);
        checkOutput("run_xdir0", 32'(dut.xdir_q[0]), 32'd1);

        // Fast step clamps at the right edge, then moves back.
        speed = 3'd7;
        doFrame(3'd7, busyCnt);
        checkOutput("clamp_x0", 32'(dut.x_q[0]), 32'd620);
        checkOutput("clamp_xdir0", 32'(dut.xdir_q[0]), 32'd0);
        doFrame(3'd7, busyCnt);
        checkOutput("return_x0", 32'(dut.x_q[0]), 32'd612);

        // Reset in the middle of an update aborts it and restores start positions.
        hpos = 10'd0;
        vpos = 10'd480;
        @(posedge clk);
        #1;
        hpos = 10'd1;
        vpos = 10'd0;
        checkOutput("abort_busy_on", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy_off", 32'(busy), 32'd0);
        checkOutput("abort_x0", 32'(dut.x_q[0]), 32'd320);
        checkOutput("abort_xdir0", 32'(dut.xdir_q[0]), 32'd1);
        checkOutput("abort_y1", 32'(dut.y_q[1]), 32'd224);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
